phase1_control_sequencer: RTL and testbench

Hardwired control unit that drives the phase1 datapath's control inputs, taking over from the bench-driven signals. It steps through fetch (T0–T2) and execute (T3–T6) states for three-register ALU ops, HI/LO ops (MUL/DIV) and NOP/HALT. It decodes the IR contents and emits bus-out, register-load, ALU-select and Gra/Grb/Grc register-select strobes for the select-and-encode logic. It sits directly upstream of the phase1 datapath.

---
 rtl/phase1_control_sequencer.sv | 169 ++++++++++++++++
 tb/tb_phase1_control_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/phase1_control_sequencer.sv
// Hardwired control sequencer for the phase1 datapath: fetch (T0-T2) then
// execute (T3-T6) for R3 ALU ops, MUL/DIV (HI/LO) ops, NOP and HALT.
// Ports: Clock/Reset (sync, active-high); IR and Stop in; bus-out enables,
// register-load enables, IncrementPC, Read, Gra/Grb/Grc, ALUControl, Run,
// InstrCount out. Strobes decode combinationally from the registered state
// and the live IR; the state advances once per posedge.
module phase1_control_sequencer #(
  parameter int IR_WIDTH = 32,
  parameter int OP_WIDTH = 5
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [IR_WIDTH-1:0] IR,
  input  logic                Stop,
  output logic                PCout,
  output logic                ZHIout,
  output logic                ZLOout,
  output logic                MDRout,
  output logic                Rout,
  output logic                PCin,
  output logic                MARin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                HIin,
  output logic                LOin,
  output logic                Rin,
  output logic                IncrementPC,
  output logic                Read,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic [OP_WIDTH-1:0] ALUControl,
  output logic                Run,
  output logic [31:0]         InstrCount
);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED
  } state_t;

  localparam logic [OP_WIDTH-1:0] OP_R3_MAX = OP_WIDTH'(5'b01100);
  localparam logic [OP_WIDTH-1:0] OP_MUL    = OP_WIDTH'(5'b00010);
  localparam logic [OP_WIDTH-1:0] OP_DIV    = OP_WIDTH'(5'b00011);
  localparam logic [OP_WIDTH-1:0] OP_HALT   = OP_WIDTH'(5'b11011);

  state_t state;
  // Instruction class captured on the T2->T3 edge so later IR changes cannot
  // alter the length of the execute sequence.
  logic   hilo;

  logic [OP_WIDTH-1:0] op;
  logic                is_hilo;
  logic                is_r3;
  logic                is_halt;
  logic                ir_unused;

  assign op        = IR[IR_WIDTH-1 -: OP_WIDTH];
  assign ir_unused = ^IR[IR_WIDTH-OP_WIDTH-1:0];
  assign is_hilo   = (op == OP_MUL) || (op == OP_DIV);
  assign is_r3     = (op <= OP_R3_MAX) && !is_hilo;
  assign is_halt   = (op == OP_HALT);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      hilo       <= 1'b0;
      InstrCount <= 32'd0;
    end else begin
      case (state)
        IDLE:   if (!Stop) state <= T0;
        T0:     state <= T1;
        T1:     state <= T2;
        T2: begin
          InstrCount <= InstrCount + 32'd1;
          if (is_halt) begin
            state <= HALTED;
          end else if (is_r3 || is_hilo) begin
            hilo  <= is_hilo;
            state <= T3;
          end else begin
            // NOP and every unassigned opcode end here.
            state <= Stop ? IDLE : T0;
          end
        end
        T3:     state <= T4;
        T4:     state <= T5;
        T5: begin
          if (hilo) state <= T6;
          else      state <= Stop ? IDLE : T0;
        end
        T6:     state <= Stop ? IDLE : T0;
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    PCout       = 1'b0;
    ZHIout      = 1'b0;
    ZLOout      = 1'b0;
    MDRout      = 1'b0;
    Rout        = 1'b0;
    PCin        = 1'b0;
    MARin       = 1'b0;
    MDRin       = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    Zin         = 1'b0;
    HIin        = 1'b0;
    LOin        = 1'b0;
    Rin         = 1'b0;
    IncrementPC = 1'b0;
    Read        = 1'b0;
    Gra         = 1'b0;
    Grb         = 1'b0;
    Grc         = 1'b0;
    ALUControl  = '0;
    Run         = (state != HALTED);
    case (state)
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        Zin   = 1'b1;
      end
      T1: begin
        ZLOout      = 1'b1;
        PCin        = 1'b1;
        IncrementPC = 1'b1;
        Read        = 1'b1;
        MDRin       = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        Rout = 1'b1;
        Yin  = 1'b1;
        if (hilo) Gra = 1'b1;
        else      Grb = 1'b1;
      end
      T4: begin
        Rout       = 1'b1;
        Zin        = 1'b1;
        ALUControl = op;
        if (hilo) Grb = 1'b1;
        else      Grc = 1'b1;
      end
      T5: begin
        ZLOout = 1'b1;
        if (hilo) begin
          LOin = 1'b1;
        end else begin
          Gra = 1'b1;
          Rin = 1'b1;
        end
      end
      T6: begin
        ZHIout = 1'b1;
        HIin   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_phase1_control_sequencer.sv
// Directed bench for phase1_control_sequencer. Stimulus pushes the expected
// outputs for each cycle into a queue; a monitor on the falling edge pops
// and compares them against the DUT.
module tb_phase1_control_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] IR    = 32'd0;
  logic        Stop  = 1'b0;
  logic PCout, ZHIout, ZLOout, MDRout, Rout;
  logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin;
  logic IncrementPC, Read, Gra, Grb, Grc, Run;
  logic [4:0]  ALUControl;
  logic [31:0] InstrCount;

  always #5 Clock = ~Clock;

  phase1_control_sequencer #(.IR_WIDTH(32), .OP_WIDTH(5)) dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Stop(Stop),
    .PCout(PCout), .ZHIout(ZHIout), .ZLOout(ZLOout), .MDRout(MDRout), .Rout(Rout),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .Rin(Rin), .IncrementPC(IncrementPC), .Read(Read),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .ALUControl(ALUControl), .Run(Run),
    .InstrCount(InstrCount)
  );

  // Strobe vector bit positions.
  localparam logic [18:0] B_PCOUT  = 19'd1 << 18;
  localparam logic [18:0] B_ZHIOUT = 19'd1 << 17;
  localparam logic [18:0] B_ZLOOUT = 19'd1 << 16;
  localparam logic [18:0] B_MDROUT = 19'd1 << 15;
  localparam logic [18:0] B_ROUT   = 19'd1 << 14;
  localparam logic [18:0] B_PCIN   = 19'd1 << 13;
  localparam logic [18:0] B_MARIN  = 19'd1 << 12;
  localparam logic [18:0] B_MDRIN  = 19'd1 << 11;
  localparam logic [18:0] B_IRIN   = 19'd1 << 10;
  localparam logic [18:0] B_YIN    = 19'd1 << 9;
  localparam logic [18:0] B_ZIN    = 19'd1 << 8;
  localparam logic [18:0] B_HIIN   = 19'd1 << 7;
  localparam logic [18:0] B_LOIN   = 19'd1 << 6;
  localparam logic [18:0] B_RIN    = 19'd1 << 5;
  localparam logic [18:0] B_INCPC  = 19'd1 << 4;
  localparam logic [18:0] B_READ   = 19'd1 << 3;
  localparam logic [18:0] B_GRA    = 19'd1 << 2;
  localparam logic [18:0] B_GRB    = 19'd1 << 1;
  localparam logic [18:0] B_GRC    = 19'd1 << 0;

  localparam logic [18:0] P_NONE  = 19'd0;
  localparam logic [18:0] P_T0    = B_PCOUT | B_MARIN | B_ZIN;
  localparam logic [18:0] P_T1    = B_ZLOOUT | B_PCIN | B_INCPC | B_READ | B_MDRIN;
  localparam logic [18:0] P_T2    = B_MDROUT | B_IRIN;
  localparam logic [18:0] P_R3_T3 = B_GRB | B_ROUT | B_YIN;
  localparam logic [18:0] P_R3_T4 = B_GRC | B_ROUT | B_ZIN;
  localparam logic [18:0] P_R3_T5 = B_ZLOOUT | B_GRA | B_RIN;
  localparam logic [18:0] P_HL_T3 = B_GRA | B_ROUT | B_YIN;
  localparam logic [18:0] P_HL_T4 = B_GRB | B_ROUT | B_ZIN;
  localparam logic [18:0] P_HL_T5 = B_ZLOOUT | B_LOIN;
  localparam logic [18:0] P_HL_T6 = B_ZHIOUT | B_HIIN;

  localparam logic [31:0] I_ADD   = 32'h2891_8000;  // op 00101
  localparam logic [31:0] I_DIV   = 32'h1B38_0000;  // op 00011
  localparam logic [31:0] I_NOP   = 32'hD000_0000;  // op 11010
  localparam logic [31:0] I_HALT  = 32'hD800_0000;  // op 11011
  localparam logic [31:0] I_OTHER = 32'hF800_0000;  // op 11111, runs as NOP

  typedef struct packed {
    logic [18:0] strb;
    logic [4:0]  alu;
    logic        run;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  logic [18:0] act_strb;
  assign act_strb = {PCout, ZHIout, ZLOout, MDRout, Rout, PCin, MARin, MDRin, IRin,
                     Yin, Zin, HIin, LOin, Rin, IncrementPC, Read, Gra, Grb, Grc};

  // Monitor: compares one expectation per cycle in which stimulus queued one.
  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (act_strb === e.strb && ALUControl === e.alu && Run === e.run &&
          InstrCount === e.cnt) begin
        passes++;
      end else begin
        $display("FAIL cycle_check#%0d t=%0t: got strb=%019b alu=%05b run=%b cnt=%0d, want strb=%019b alu=%05b run=%b cnt=%0d",
                 checks, $time, act_strb, ALUControl, Run, InstrCount,
                 e.strb, e.alu, e.run, e.cnt);
      end
    end
  end

  // Drive inputs for this cycle, queue the outputs expected in this cycle,
  // then advance to just after the next rising edge.
  task automatic cyc(input logic rst, input logic stp, input logic [31:0] ir,
                     input logic [18:0] s, input logic [4:0] a, input logic r,
                     input logic [31:0] c);
    exp_t e;
    Reset = rst;
    Stop  = stp;
    IR    = ir;
    e.strb = s;
    e.alu  = a;
    e.run  = r;
    e.cnt  = c;
    exp_q.push_back(e);
    @(posedge Clock);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ir, input logic stp_t2, input logic [31:0] c);
    cyc(1'b0, 1'b0,   ir, P_T0, 5'd0, 1'b1, c);
    cyc(1'b0, 1'b0,   ir, P_T1, 5'd0, 1'b1, c);
    cyc(1'b0, stp_t2, ir, P_T2, 5'd0, 1'b1, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    // Reset held two cycles, then one IDLE cycle before fetch starts.
    cyc(1'b1, 1'b0, I_ADD, P_NONE, 5'd0, 1'b1, 32'd0);
    cyc(1'b0, 1'b0, I_ADD, P_NONE, 5'd0, 1'b1, 32'd0);

    // ADD R1,R2,R3; IR is garbage until T2, Stop pulses in T3 only.
    cyc(1'b0, 1'b0, I_HALT, P_T0, 5'd0, 1'b1, 32'd0);
    cyc(1'b0, 1'b0, I_HALT, P_T1, 5'd0, 1'b1, 32'd0);
    cyc(1'b0, 1'b0, I_ADD,  P_T2, 5'd0, 1'b1, 32'd0);
    cyc(1'b0, 1'b1, I_ADD, P_R3_T3, 5'd0,      1'b1, 32'd1);
    cyc(1'b0, 1'b0, I_ADD, P_R3_T4, 5'b00101,  1'b1, 32'd1);
    cyc(1'b0, 1'b0, I_ADD, P_R3_T5, 5'd0,      1'b1, 32'd1);

    // DIV R6,R7 back to back with no Stop.
    fetch(I_DIV, 1'b0, 32'd1);
    cyc(1'b0, 1'b0, I_DIV, P_HL_T3, 5'd0,     1'b1, 32'd2);
    cyc(1'b0, 1'b0, I_DIV, P_HL_T4, 5'b00011, 1'b1, 32'd2);
    cyc(1'b0, 1'b0, I_DIV, P_HL_T5, 5'd0,     1'b1, 32'd2);
    cyc(1'b0, 1'b0, I_DIV, P_HL_T6, 5'd0,     1'b1, 32'd2);

    // DIV with Stop raised in T4 and held: finishes T6, then parks in IDLE.
    fetch(I_DIV, 1'b0, 32'd2);
    cyc(1'b0, 1'b0, I_DIV, P_HL_T3, 5'd0,     1'b1, 32'd3);
    cyc(1'b0, 1'b1, I_DIV, P_HL_T4, 5'b00011, 1'b1, 32'd3);
    cyc(1'b0, 1'b1, I_DIV, P_HL_T5, 5'd0,     1'b1, 32'd3);
    cyc(1'b0, 1'b1, I_DIV, P_HL_T6, 5'd0,     1'b1, 32'd3);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, I_NOP, P_NONE, 5'd0, 1'b1, 32'd3);
    cyc(1'b0, 1'b0, I_NOP, P_NONE, 5'd0, 1'b1, 32'd3);

    // NOP returns straight to T0; unassigned opcode with Stop goes to IDLE.
    fetch(I_NOP,   1'b0, 32'd3);
    fetch(I_OTHER, 1'b1, 32'd4);
    cyc(1'b0, 1'b0, I_HALT, P_NONE, 5'd0, 1'b1, 32'd5);

    // HALT: absorbing, Run low, strobes quiet; only Reset leaves.
    fetch(I_HALT, 1'b0, 32'd5);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, I_NOP, P_NONE, 5'd0, 1'b0, 32'd6);
    cyc(1'b1, 1'b0, I_NOP, P_NONE, 5'd0, 1'b0, 32'd6);
    cyc(1'b0, 1'b0, I_ADD, P_NONE, 5'd0, 1'b1, 32'd0);

    // Reset in T4 of an R3 op aborts to IDLE with the count cleared.
    fetch(I_ADD, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, I_ADD, P_R3_T3, 5'd0,     1'b1, 32'd1);
    cyc(1'b1, 1'b0, I_ADD, P_R3_T4, 5'b00101, 1'b1, 32'd1);
    cyc(1'b0, 1'b1, I_ADD, P_NONE,  5'd0,     1'b1, 32'd0);
    cyc(1'b0, 1'b1, I_ADD, P_NONE,  5'd0,     1'b1, 32'd0);

    @(negedge Clock);
    #1;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
